// File: rtl/mcb_cmd_arbiter_if.sv
// Signal bundle for mcb_cmd_arbiter: both requester command ports, the MCB
// command port, FIFO status, counters and the FSM debug view.
interface mcb_cmd_arbiter_if;
  // Handshake: a requester raises *_cmd_valid_in with stable addr/bl and holds
  // them until its one-cycle *_cmd_ack_out; it may change them the cycle after.
  logic        wr_cmd_valid_in;
  logic [29:0] wr_cmd_addr_in;
  logic [5:0]  wr_cmd_bl_in;
  logic        wr_cmd_ack_out;
  logic        rd_cmd_valid_in;
  logic [29:0] rd_cmd_addr_in;
  logic [5:0]  rd_cmd_bl_in;
  logic        rd_cmd_ack_out;
  logic        mcb_cmd_en_out;
  logic [2:0]  mcb_cmd_instr_out;
  logic [5:0]  mcb_cmd_bl_out;
  logic [29:0] mcb_cmd_byte_addr_out;
  logic        mcb_cmd_full_in;
  logic [6:0]  mcb_wr_count_in;
  logic        mcb_rd_pop_in;
  logic [6:0]  rd_outstanding_out;
  logic [15:0] stat_wr_cmds_out;
  logic [15:0] stat_rd_cmds_out;
  logic [1:0]  dbg_state_out;

  modport slave (
    input  wr_cmd_valid_in, wr_cmd_addr_in, wr_cmd_bl_in,
    input  rd_cmd_valid_in, rd_cmd_addr_in, rd_cmd_bl_in,
    input  mcb_cmd_full_in, mcb_wr_count_in, mcb_rd_pop_in,
    output wr_cmd_ack_out, rd_cmd_ack_out,
    output mcb_cmd_en_out, mcb_cmd_instr_out, mcb_cmd_bl_out, mcb_cmd_byte_addr_out,
    output rd_outstanding_out, stat_wr_cmds_out, stat_rd_cmds_out, dbg_state_out
  );

  modport master (
    output wr_cmd_valid_in, wr_cmd_addr_in, wr_cmd_bl_in,
    output rd_cmd_valid_in, rd_cmd_addr_in, rd_cmd_bl_in,
    output mcb_cmd_full_in, mcb_wr_count_in, mcb_rd_pop_in,
    input  wr_cmd_ack_out, rd_cmd_ack_out,
    input  mcb_cmd_en_out, mcb_cmd_instr_out, mcb_cmd_bl_out, mcb_cmd_byte_addr_out,
    input  rd_outstanding_out, stat_wr_cmds_out, stat_rd_cmds_out, dbg_state_out
  );
endinterface

// File: rtl/mcb_cmd_arbiter.sv
// Read-priority arbiter for the shared MCB command port with write-starvation guard.
// Optional command counters are built when MCB_ARB_STATS_EN is defined.
module mcb_cmd_arbiter #(
  parameter int RD_FIFO_DEPTH = 64,
  parameter int WR_STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  mcb_cmd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam int            SW         = $clog2(WR_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(WR_STARVE_MAX);
  localparam logic [7:0]    RD_DEPTH8  = 8'(RD_FIFO_DEPTH);
  localparam logic [2:0]    INSTR_WR   = 3'b000;
  localparam logic [2:0]    INSTR_RD   = 3'b001;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_q, starve_nxt;
  logic [6:0]    rd_out_q, rd_out_nxt;
  logic [2:0]    instr_q;
  logic [5:0]    bl_q;
  logic [29:0]   addr_q;
  logic          wr_elig, rd_elig;
  logic          grant_rd, grant_wr;
  logic [7:0]    rd_need;
  logic          rd_issue;

  // Write needs its whole burst already in the MCB write FIFO; read needs
  // room in the read FIFO for its whole burst on top of what is in flight.
  assign wr_elig = bus.wr_cmd_valid_in &&
                   (bus.mcb_wr_count_in >= ({1'b0, bus.wr_cmd_bl_in} + 7'd1));
  assign rd_need = {1'b0, rd_out_q} + {2'b00, bus.rd_cmd_bl_in} + 8'd1;
  assign rd_elig = bus.rd_cmd_valid_in && (rd_need <= RD_DEPTH8);

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_q;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.mcb_cmd_full_in) begin
          if (rd_elig && !((starve_q == STARVE_MAX) && wr_elig)) grant_rd = 1'b1;
          else if (wr_elig)                                     grant_wr = 1'b1;
        end
        if (grant_rd || grant_wr) state_nxt = S_ISSUE;
        if (!bus.wr_cmd_valid_in || grant_wr)
          starve_nxt = '0;
        else if (grant_rd && wr_elig && (starve_q != STARVE_MAX))
          starve_nxt = starve_q + SW'(1);
      end
      S_ISSUE: state_nxt = S_HOLD;
      S_HOLD:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_issue = (state == S_ISSUE) && (instr_q == INSTR_RD);

  // Issue and pop in the same cycle both apply; a pop with nothing in flight is dropped.
  always_comb begin
    rd_out_nxt = rd_out_q;
    if (rd_issue) rd_out_nxt = rd_out_nxt + {1'b0, bl_q} + 7'd1;
    if (bus.mcb_rd_pop_in && (rd_out_q != '0)) rd_out_nxt = rd_out_nxt - 7'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      starve_q <= '0;
      rd_out_q <= '0;
      instr_q  <= '0;
      bl_q     <= '0;
      addr_q   <= '0;
    end else begin
      state    <= state_nxt;
      starve_q <= starve_nxt;
      rd_out_q <= rd_out_nxt;
      if (grant_rd) begin
        instr_q <= INSTR_RD;
        bl_q    <= bus.rd_cmd_bl_in;
        addr_q  <= bus.rd_cmd_addr_in;
      end else if (grant_wr) begin
        instr_q <= INSTR_WR;
        bl_q    <= bus.wr_cmd_bl_in;
        addr_q  <= bus.wr_cmd_addr_in;
      end
    end
  end

  assign bus.mcb_cmd_en_out        = (state == S_ISSUE);
  assign bus.wr_cmd_ack_out        = (state == S_ISSUE) && (instr_q == INSTR_WR);
  assign bus.rd_cmd_ack_out        = rd_issue;
  assign bus.mcb_cmd_instr_out     = instr_q;
  assign bus.mcb_cmd_bl_out        = bl_q;
  assign bus.mcb_cmd_byte_addr_out = addr_q;
  assign bus.rd_outstanding_out    = rd_out_q;
  assign bus.dbg_state_out         = state;

`ifdef MCB_ARB_STATS_EN
  logic [15:0] stat_wr_q, stat_rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else if (state == S_ISSUE) begin
      if (instr_q == INSTR_RD) stat_rd_q <= stat_rd_q + 16'd1;
      else                     stat_wr_q <= stat_wr_q + 16'd1;
    end
  end

  assign bus.stat_wr_cmds_out = stat_wr_q;
  assign bus.stat_rd_cmds_out = stat_rd_q;
`else
  assign bus.stat_wr_cmds_out = '0;
  assign bus.stat_rd_cmds_out = '0;
`endif

endmodule

// File: tb/tb_mcb_cmd_arbiter.sv
// Bench for mcb_cmd_arbiter: directed scenarios, a cycle-level behavioural
// model with a command scoreboard, and literal pins on key values.
module tb_mcb_cmd_arbiter;
  localparam int RD_DEPTH = 64;
  localparam int STARVE   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcb_cmd_arbiter_if bus();

  mcb_cmd_arbiter #(.RD_FIFO_DEPTH(RD_DEPTH), .WR_STARVE_MAX(STARVE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 = waiting to arbitrate, 1 = command on the port, 2 = cooldown.
  int          m_phase  = 0;
  int          m_out    = 0;
  int          m_starve = 0;
  logic [15:0] m_st_wr  = '0;
  logic [15:0] m_st_rd  = '0;
  logic [38:0] m_cmd    = '0;
  logic [38:0] exp_q[$];

  always @(posedge clk) begin : model
    int old_out;
    bit wr_ok, rd_ok, g_rd, g_wr;
    if (rst) begin
      m_phase  = 0;
      m_out    = 0;
      m_starve = 0;
      m_st_wr  = '0;
      m_st_rd  = '0;
      m_cmd    = '0;
      exp_q.delete();
    end else begin
      old_out = m_out;
      if (m_phase == 1) begin
        if (m_cmd[38:36] == 3'b001) begin
          m_out   = m_out + int'(m_cmd[35:30]) + 1;
          m_st_rd = m_st_rd + 16'd1;
        end else begin
          m_st_wr = m_st_wr + 16'd1;
        end
      end
      if (bus.mcb_rd_pop_in && old_out > 0) m_out = m_out - 1;
      if (m_phase == 1)      m_phase = 2;
      else if (m_phase == 2) m_phase = 0;
      else begin
        wr_ok = bus.wr_cmd_valid_in && (int'(bus.mcb_wr_count_in) >= int'(bus.wr_cmd_bl_in) + 1);
        rd_ok = bus.rd_cmd_valid_in && (old_out + int'(bus.rd_cmd_bl_in) + 1 <= RD_DEPTH);
        g_rd  = 1'b0;
        g_wr  = 1'b0;
        if (!bus.mcb_cmd_full_in) begin
          if (rd_ok && !(m_starve == STARVE && wr_ok)) g_rd = 1'b1;
          else if (wr_ok)                              g_wr = 1'b1;
        end
        if (!bus.wr_cmd_valid_in || g_wr)                  m_starve = 0;
        else if (g_rd && wr_ok && m_starve < STARVE)       m_starve = m_starve + 1;
        if (g_rd) m_cmd = {3'b001, bus.rd_cmd_bl_in, bus.rd_cmd_addr_in};
        if (g_wr) m_cmd = {3'b000, bus.wr_cmd_bl_in, bus.wr_cmd_addr_in};
        if (g_rd || g_wr) begin
          exp_q.push_back(m_cmd);
          m_phase = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic [38:0] act_cmd;
    if (chk_en) begin
      act_cmd = {bus.mcb_cmd_instr_out, bus.mcb_cmd_bl_out, bus.mcb_cmd_byte_addr_out};
      chk("cyc_en", bus.mcb_cmd_en_out, m_phase == 1);
      chk("cyc_wr_ack", bus.wr_cmd_ack_out, (m_phase == 1) && (m_cmd[38:36] == 3'b000));
      chk("cyc_rd_ack", bus.rd_cmd_ack_out, (m_phase == 1) && (m_cmd[38:36] == 3'b001));
      chk("cyc_cmd_fields", act_cmd, m_cmd);
      chk("cyc_outstanding", bus.rd_outstanding_out, m_out);
`ifdef MCB_ARB_STATS_EN
      chk("cyc_stat_wr", bus.stat_wr_cmds_out, m_st_wr);
      chk("cyc_stat_rd", bus.stat_rd_cmds_out, m_st_rd);
`else
      chk("cyc_stat_wr", bus.stat_wr_cmds_out, 0);
      chk("cyc_stat_rd", bus.stat_rd_cmds_out, 0);
`endif
      if (bus.mcb_cmd_en_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_cmd got=0x%0h exp=none", act_cmd);
        end else begin
          chk("sb_cmd", act_cmd, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_en(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.mcb_cmd_en_out && cyc < budget);
    chk("wait_en_timeout", bus.mcb_cmd_en_out, 1);
  endtask

  task automatic watch_no_en(input string name, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      seen = seen | bus.mcb_cmd_en_out;
    end
    chk(name, seen, 0);
  endtask

  task automatic pop_n(input int n);
    bus.mcb_rd_pop_in = 1'b1;
    repeat (n) @(negedge clk);
    bus.mcb_rd_pop_in = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int    cyc;
    int    n;
    string seq;
    bus.wr_cmd_valid_in = 1'b0;
    bus.wr_cmd_addr_in  = '0;
    bus.wr_cmd_bl_in    = '0;
    bus.rd_cmd_valid_in = 1'b0;
    bus.rd_cmd_addr_in  = '0;
    bus.rd_cmd_bl_in    = '0;
    bus.mcb_cmd_full_in = 1'b0;
    bus.mcb_wr_count_in = '0;
    bus.mcb_rd_pop_in   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_en", bus.mcb_cmd_en_out, 0);
    chk("rst_acks", {bus.wr_cmd_ack_out, bus.rd_cmd_ack_out}, 0);
    chk("rst_cmd", {bus.mcb_cmd_instr_out, bus.mcb_cmd_bl_out, bus.mcb_cmd_byte_addr_out}, 0);
    chk("rst_outstanding", bus.rd_outstanding_out, 0);
    chk("rst_state", bus.dbg_state_out, 0);
    chk("rst_stats", {bus.stat_wr_cmds_out, bus.stat_rd_cmds_out}, 0);
    rst = 1'b0;

    // Write only
    bus.mcb_wr_count_in = 7'd8;
    bus.wr_cmd_bl_in    = 6'd7;
    bus.wr_cmd_addr_in  = 30'h100;
    bus.wr_cmd_valid_in = 1'b1;
    wait_en(10, cyc);
    chk("wr_only_latency", cyc, 1);
    chk("wr_only_instr", bus.mcb_cmd_instr_out, 3'b000);
    chk("wr_only_bl", bus.mcb_cmd_bl_out, 7);
    chk("wr_only_addr", bus.mcb_cmd_byte_addr_out, 30'h100);
    chk("wr_only_ack", bus.wr_cmd_ack_out, 1);
    bus.wr_cmd_valid_in = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n += int'(bus.wr_cmd_ack_out);
    end
    chk("wr_only_single_ack", n, 0);

    // Write gating on MCB write FIFO fill
    bus.mcb_wr_count_in = 7'd3;
    bus.wr_cmd_addr_in  = 30'h140;
    bus.wr_cmd_valid_in = 1'b1;
    watch_no_en("wr_gate_blocked", 6);
    bus.mcb_wr_count_in = 7'd8;
    wait_en(10, cyc);
    chk("wr_gate_latency", cyc, 1);
    chk("wr_gate_addr", bus.mcb_cmd_byte_addr_out, 30'h140);
    bus.wr_cmd_valid_in = 1'b0;
    repeat (3) @(negedge clk);

    // Both continuously eligible: starvation guard shapes the order
    bus.wr_cmd_addr_in  = 30'h200;
    bus.rd_cmd_bl_in    = 6'd0;
    bus.rd_cmd_addr_in  = 30'h300;
    bus.wr_cmd_valid_in = 1'b1;
    bus.rd_cmd_valid_in = 1'b1;
    seq = "";
    for (int i = 0; i < 10; i++) begin
      wait_en(12, cyc);
      if (i > 0) chk("arb_issue_gap", cyc, 3);
      seq = {seq, (bus.mcb_cmd_instr_out == 3'b001) ? "R" : "W"};
    end
    bus.wr_cmd_valid_in = 1'b0;
    bus.rd_cmd_valid_in = 1'b0;
    checks++;
    if (seq != "RRRRWRRRRW") begin
      failures++;
      $display("FAIL arb_order got=%s exp=RRRRWRRRRW", seq);
    end
    repeat (2) @(negedge clk);
    chk("arb_outstanding", bus.rd_outstanding_out, 8);
    pop_n(10);
    chk("pop_no_underflow", bus.rd_outstanding_out, 0);

    // Read gating on read FIFO space
    bus.rd_cmd_bl_in    = 6'd15;
    bus.rd_cmd_addr_in  = 30'h400;
    bus.rd_cmd_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) wait_en(12, cyc);
    watch_no_en("rd_gate_blocked", 6);
    chk("rd_gate_out64", bus.rd_outstanding_out, 64);
    pop_n(16);
    chk("rd_gate_out48", bus.rd_outstanding_out, 48);
    chk("rd_gate_not_yet", bus.mcb_cmd_en_out, 0);
    wait_en(10, cyc);
    chk("rd_gate_5th_latency", cyc, 1);
    chk("rd_gate_5th_instr", bus.mcb_cmd_instr_out, 3'b001);
    bus.rd_cmd_valid_in = 1'b0;
    @(negedge clk);
    chk("rd_gate_out_after5", bus.rd_outstanding_out, 64);
    pop_n(64);
    chk("rd_gate_drained", bus.rd_outstanding_out, 0);

    // Command FIFO full holds everything; read goes first once it clears
    bus.mcb_cmd_full_in = 1'b1;
    bus.rd_cmd_bl_in    = 6'd0;
    bus.rd_cmd_addr_in  = 30'h500;
    bus.wr_cmd_addr_in  = 30'h600;
    bus.wr_cmd_valid_in = 1'b1;
    bus.rd_cmd_valid_in = 1'b1;
    watch_no_en("full_blocked", 5);
    bus.mcb_cmd_full_in = 1'b0;
    wait_en(10, cyc);
    chk("full_first_instr", bus.mcb_cmd_instr_out, 3'b001);
    chk("full_first_addr", bus.mcb_cmd_byte_addr_out, 30'h500);
    bus.rd_cmd_valid_in = 1'b0;
    wait_en(10, cyc);
    chk("full_second_instr", bus.mcb_cmd_instr_out, 3'b000);
    bus.wr_cmd_valid_in = 1'b0;
    pop_n(3);
    chk("full_drained", bus.rd_outstanding_out, 0);

    // Reset in the middle of an issue
    bus.rd_cmd_bl_in    = 6'd15;
    bus.rd_cmd_addr_in  = 30'h700;
    bus.rd_cmd_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) wait_en(12, cyc);
    chk("rst_mid_out32", bus.rd_outstanding_out, 32);
    rst = 1'b1;
    bus.rd_cmd_valid_in = 1'b0;
    @(negedge clk);
    chk("rst_mid_en", bus.mcb_cmd_en_out, 0);
    chk("rst_mid_acks", {bus.wr_cmd_ack_out, bus.rd_cmd_ack_out}, 0);
    chk("rst_mid_outstanding", bus.rd_outstanding_out, 0);
    chk("rst_mid_state", bus.dbg_state_out, 0);
    chk("rst_mid_stats", {bus.stat_wr_cmds_out, bus.stat_rd_cmds_out}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcb_cmd_arbiter.md
Name: mcb_cmd_arbiter

Overview:
- Shares the single DRAM MCB command port between two requesters.
- Write requester: the Ethernet-to-DRAM writer, which loads framebuffer data.
- Read requester: the display framebuffer fetch path.
- Read has priority (real-time display), with a bounded write-starvation guard.
- Commands are gated on MCB write-FIFO fill level and read-FIFO free space, so the MCB never underruns or overflows.

Parameters:
- RD_FIFO_DEPTH, 64: MCB read data FIFO capacity in 64-bit words.
- WR_STARVE_MAX, 4: consecutive read grants allowed while an eligible write waits.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- wr_cmd_valid_in  in  1  write command request, held until acked
- wr_cmd_addr_in  in  30  write byte address
- wr_cmd_bl_in  in  6  write burst length minus 1
- wr_cmd_ack_out  out  1  one-cycle pulse; write command issued
- rd_cmd_valid_in  in  1  read command request, held until acked
- rd_cmd_addr_in  in  30  read byte address
- rd_cmd_bl_in  in  6  read burst length minus 1
- rd_cmd_ack_out  out  1  one-cycle pulse; read command issued
- mcb_cmd_en_out  out  1  MCB command strobe
- mcb_cmd_instr_out  out  3  3'b000 write, 3'b001 read
- mcb_cmd_bl_out  out  6  burst length minus 1
- mcb_cmd_byte_addr_out  out  30  byte address
- mcb_cmd_full_in  in  1  MCB command FIFO full
- mcb_wr_count_in  in  7  words currently in MCB write FIFO
- mcb_rd_pop_in  in  1  read data consumer popped one word this cycle
- rd_outstanding_out  out  7  read words requested and not yet popped
- stat_wr_cmds_out  out  16  write commands issued (optional feature)
- stat_rd_cmds_out  out  16  read commands issued (optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; starvation counter 0; outstanding 0.
- Eligibility:
  - Write is eligible when wr_cmd_valid_in and mcb_wr_count_in >= wr_cmd_bl_in+1, compared at 7 bits.
  - Read is eligible when rd_cmd_valid_in and rd_outstanding + rd_cmd_bl_in + 1 <= RD_FIFO_DEPTH, computed at 8 bits.
- States:
  - IDLE: if mcb_cmd_full_in, stay. Otherwise select a winner; if neither is eligible, stay.
  - ISSUE: drive the latched command. mcb_cmd_en_out=1 and the matching ack=1 for exactly this cycle, then go to HOLD.
  - HOLD: one cooldown cycle so the full flag and counts update; then go to IDLE.
- Maximum issue rate is one command per 3 cycles.
- Latency: the command is selected in IDLE cycle N; en, ack, addr, bl and instr are valid at N+1.
- Arbitration:
  - Read wins if eligible, unless the starvation counter == WR_STARVE_MAX and write is eligible; then write wins.
  - If only one requester is eligible, it wins.
- Starvation counter:
  - Increments on each read grant made while write is eligible, saturating at WR_STARVE_MAX.
  - Clears on a write grant or on any IDLE cycle where write is not valid.
- Command outputs (addr, bl, instr) hold their last values outside ISSUE; en is 0 outside ISSUE.
- Outstanding counter:
  - Adds bl+1 in the ISSUE cycle of a read.
  - Subtracts 1 per mcb_rd_pop_in.
  - A simultaneous issue and pop apply both in the same cycle.
  - A pop when outstanding == 0 is ignored (no underflow).
- Requester inputs are sampled only in IDLE. Changes while in ISSUE or HOLD do not affect the in-flight command.
- rst mid-command: the state machine returns to IDLE, en and ack drop next cycle, and outstanding clears. The owner must also reset the MCB FIFOs.

Optional Feature:
- MCB_ARB_STATS_EN defined: stat_wr_cmds_out and stat_rd_cmds_out increment in each ISSUE cycle of their type. They are 16-bit, wrap at 0xFFFF->0, and clear on rst.
- Undefined: both stat ports tied to 0 and no counter logic built.

Test Plan:
- Write only: mcb_wr_count_in=8, write request bl=7, addr=0x100 -> en=1 one cycle later with instr=000, bl=7, addr=0x100; wr_cmd_ack_out pulses once.
- Write gating: mcb_wr_count_in=3, write request bl=7 -> no command issued; raise count to 8 -> command issued 1 cycle after the next IDLE sample.
- Both requesters continuously valid and eligible, WR_STARVE_MAX=4 -> grant order R,R,R,R,W,R,R,R,R,W,...
- Read gating: 4 reads with bl=15 and no pops -> outstanding=64, 5th read blocked; 16 pops -> outstanding=48, 5th read issued.
- mcb_cmd_full_in=1 with both requests valid -> no en; deassert full -> read issued first.
- rst asserted during ISSUE with outstanding=32 -> next cycle en=0, ack=0, outstanding=0, state IDLE; with MCB_ARB_STATS_EN, stats read 0.
